// File: rtl/hazard_scoreboard_unit_if.sv
// ID-stage hazard bundle between the pipeline (master) and the hazard/scoreboard unit (slave).
// Outputs are combinational from the ID fields; there is no backpressure, stall/flush are the flow control.
interface hazard_scoreboard_unit_if #(
    parameter int RA_W  = 5,
    parameter int CNT_W = 16,
    parameter int SEL_W = 2
);
    logic             id_valid;
    logic [RA_W-1:0]  id_rs;
    logic [RA_W-1:0]  id_rt;
    logic             r1_used;
    logic             r2_used;
    logic             hi_used;
    logic             lo_used;
    logic             id_regwrite;
    logic [RA_W-1:0]  id_wbreg;
    logic             id_load;
    logic             id_hiwrite;
    logic             id_lowrite;
    logic             ex_branch;
    logic             halt_req;
    logic             go;
    logic             stall;
    logic             flush;
    logic             halted;
    logic [SEL_W-1:0] fwd_rs;
    logic [SEL_W-1:0] fwd_rt;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_valid, id_rs, id_rt, r1_used, r2_used, hi_used, lo_used,
               id_regwrite, id_wbreg, id_load, id_hiwrite, id_lowrite,
               ex_branch, halt_req, go,
        input  stall, flush, halted, fwd_rs, fwd_rt, cycle_cnt, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, r1_used, r2_used, hi_used, lo_used,
               id_regwrite, id_wbreg, id_load, id_hiwrite, id_lowrite,
               ex_branch, halt_req, go,
        output stall, flush, halted, fwd_rs, fwd_rt, cycle_cnt, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// Scoreboard-based ID hazard unit: stall/flush/forward selects, SYSCALL halt FSM, perf counters.
// Zero-latency stall/flush/fwd from ID fields and scoreboard; the scoreboard freezes while halted.
module hazard_scoreboard_unit #(
    parameter int DEPTH  = 3,
    parameter int FWD_EN = 0,
    parameter int RA_W   = 5,
    parameter int CNT_W  = 16,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    CLR,
    hazard_scoreboard_unit_if.slave hz
);
    typedef struct packed {
        logic            v;
        logic            regwrite;
        logic [RA_W-1:0] wbreg;
        logic            load;
        logic            hiwrite;
        logic            lowrite;
    } ent_t;

    typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

    ent_t             sb_q [1:DEPTH];
    state_t           state_q;
    logic             go_q;
    logic [CNT_W-1:0] cycle_cnt_q, stall_cnt_q, flush_cnt_q;

    logic [DEPTH-1:1] m_rs, m_rt;
    logic             hilo_hz, raw_stall, run, stall_c, flush_c;
    logic [SEL_W-1:0] sel_rs, sel_rt;
    ent_t             id_ent_d;

    assign run = (state_q == RUN);

    always_comb begin
        m_rs    = '0;
        m_rt    = '0;
        hilo_hz = 1'b0;
        sel_rs  = '0;
        sel_rt  = '0;
        // Scan oldest to youngest so the youngest matching write ends up selected.
        for (int k = DEPTH - 1; k >= 1; k--) begin
            m_rs[k] = sb_q[k].v && sb_q[k].regwrite && (sb_q[k].wbreg != '0) &&
                      (sb_q[k].wbreg == hz.id_rs) && hz.r1_used;
            m_rt[k] = sb_q[k].v && sb_q[k].regwrite && (sb_q[k].wbreg != '0) &&
                      (sb_q[k].wbreg == hz.id_rt) && hz.r2_used;
            if (m_rs[k]) sel_rs = SEL_W'(k);
            if (m_rt[k]) sel_rt = SEL_W'(k);
            if (sb_q[k].v && ((sb_q[k].hiwrite && hz.hi_used) || (sb_q[k].lowrite && hz.lo_used)))
                hilo_hz = 1'b1;
        end
        if (FWD_EN != 0)
            raw_stall = hilo_hz | (sb_q[1].v & sb_q[1].load & (m_rs[1] | m_rt[1]));
        else
            raw_stall = hilo_hz | (|m_rs) | (|m_rt);

        flush_c = run & hz.ex_branch;
        stall_c = run & ~flush_c & raw_stall;

        id_ent_d          = '0;
        id_ent_d.v        = 1'b1;
        id_ent_d.regwrite = hz.id_regwrite;
        id_ent_d.wbreg    = hz.id_wbreg;
        id_ent_d.load     = hz.id_load;
        id_ent_d.hiwrite  = hz.id_hiwrite;
        id_ent_d.lowrite  = hz.id_lowrite;
    end

    assign hz.stall     = stall_c;
    assign hz.flush     = flush_c;
    assign hz.halted    = (state_q == HALT);
    assign hz.fwd_rs    = (FWD_EN != 0 && !stall_c && !flush_c) ? sel_rs : '0;
    assign hz.fwd_rt    = (FWD_EN != 0 && !stall_c && !flush_c) ? sel_rt : '0;
    assign hz.cycle_cnt = cycle_cnt_q;
    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;

    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            for (int k = 1; k <= DEPTH; k++) sb_q[k] <= '0;
            state_q     <= RUN;
            go_q        <= 1'b0;
            cycle_cnt_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            go_q <= hz.go;
            case (state_q)
                RUN: begin
                    for (int k = DEPTH; k >= 2; k--) sb_q[k] <= sb_q[k-1];
                    sb_q[1] <= (stall_c || flush_c || !hz.id_valid) ? '0 : id_ent_d;
                    if (~&cycle_cnt_q)            cycle_cnt_q <= cycle_cnt_q + 1'b1;
                    if (stall_c && ~&stall_cnt_q) stall_cnt_q <= stall_cnt_q + 1'b1;
                    if (flush_c && ~&flush_cnt_q) flush_cnt_q <= flush_cnt_q + 1'b1;
                    if (hz.halt_req) state_q <= HALT;
                end
                HALT: begin
                    if (hz.go && !go_q) state_q <= RUN;
                end
                default: state_q <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench: dut_a is stall-only, dut_b forwards with a 4-bit counter width to reach saturation.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
module tb_hazard_scoreboard_unit;
    logic clk;
    logic clr_a, clr_b;
    int   n_vec, n_err;
    int   exp_cyc_a;
    bit   run_a, run_b;

    hazard_scoreboard_unit_if                ia ();
    hazard_scoreboard_unit_if #(.CNT_W(4))   ib ();

    hazard_scoreboard_unit #(.FWD_EN(0)) dut_a (.clk(clk), .CLR(clr_a), .hz(ia));
    hazard_scoreboard_unit #(.FWD_EN(1), .CNT_W(4)) dut_b (.clk(clk), .CLR(clr_b), .hz(ib));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (run_a) exp_cyc_a++;
        #1;
    endtask

    task automatic id_a(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic r1, input logic r2, input logic rw,
                        input logic [4:0] wb, input logic ld);
        ia.id_valid = v;  ia.id_rs = rs; ia.id_rt = rt; ia.r1_used = r1; ia.r2_used = r2;
        ia.id_regwrite = rw; ia.id_wbreg = wb; ia.id_load = ld;
        ia.id_hiwrite = 1'b0; ia.id_lowrite = 1'b0; ia.hi_used = 1'b0; ia.lo_used = 1'b0;
    endtask

    task automatic id_b(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic r1, input logic r2, input logic rw,
                        input logic [4:0] wb, input logic ld);
        ib.id_valid = v;  ib.id_rs = rs; ib.id_rt = rt; ib.r1_used = r1; ib.r2_used = r2;
        ib.id_regwrite = rw; ib.id_wbreg = wb; ib.id_load = ld;
        ib.id_hiwrite = 1'b0; ib.id_lowrite = 1'b0; ib.hi_used = 1'b0; ib.lo_used = 1'b0;
    endtask

    initial begin
        n_vec = 0; n_err = 0; exp_cyc_a = 0; run_a = 0; run_b = 0;
        clr_a = 1'b1; clr_b = 1'b1;
        id_a(0, 0, 0, 0, 0, 0, 0, 0); id_b(0, 0, 0, 0, 0, 0, 0, 0);
        ia.ex_branch = 0; ia.halt_req = 0; ia.go = 0;
        ib.ex_branch = 0; ib.halt_req = 0; ib.go = 0;
        #1;
        chk("a_rst_stall",  ia.stall, 0);
        chk("a_rst_flush",  ia.flush, 0);
        chk("a_rst_halted", ia.halted, 0);
        chk("a_rst_fwd",    {ia.fwd_rs, ia.fwd_rt}, 0);
        chk("a_rst_cnts",   {ia.cycle_cnt, ia.stall_cnt}, 0);
        chk("b_rst_cnts",   {ib.cycle_cnt, ib.stall_cnt, ib.flush_cnt}, 0);

        @(negedge clk);
        clr_a = 1'b0; clr_b = 1'b0; run_a = 1; run_b = 1;
        tick();

        // ---- stall-only unit ----
        id_a(1, 1, 2, 1, 1, 1, 3, 0); #1;                 // ADDU $3
        chk("a_addu_nostall", ia.stall, 0);
        tick();
        id_a(1, 3, 4, 1, 1, 1, 6, 0); #1;                 // SUBU $6, $3, $4
        chk("a_raw_stall1", ia.stall, 1);
        chk("a_raw_fwd0",   ia.fwd_rs, 0);
        tick();
        chk("a_raw_stall2", ia.stall, 1);
        tick();
        chk("a_raw_release", ia.stall, 0);
        chk("a_stall_cnt2",  ia.stall_cnt, 2);
        tick();
        id_a(1, 0, 0, 0, 0, 1, 0, 0);                     // write to $0
        tick();
        id_a(1, 0, 0, 1, 1, 0, 0, 0); #1;
        chk("a_r0_nostall", ia.stall, 0);
        tick();
        id_a(1, 1, 0, 1, 0, 0, 0, 0); ia.id_hiwrite = 1;  // MTHI
        tick();
        id_a(1, 0, 0, 0, 0, 1, 2, 0); ia.hi_used = 1; #1; // MFHI $2
        chk("a_hi_stall1", ia.stall, 1);
        tick();
        chk("a_hi_stall2", ia.stall, 1);
        tick();
        chk("a_hi_release", ia.stall, 0);
        tick();
        id_a(1, 0, 0, 0, 0, 1, 7, 0);                     // ADDU $7
        tick();
        id_a(1, 7, 0, 1, 0, 0, 0, 0); ia.ex_branch = 1; #1;
        chk("a_br_flush", ia.flush, 1);
        chk("a_br_stall", ia.stall, 0);
        tick();
        ia.ex_branch = 0; #1;
        chk("a_post_br_stall", ia.stall, 1);
        chk("a_flush_cnt1",    ia.flush_cnt, 1);
        id_a(0, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        chk("a_stall_cnt4", ia.stall_cnt, 4);

        ia.halt_req = 1; #1;
        chk("a_halted_pre", ia.halted, 0);
        tick();
        ia.halt_req = 0; run_a = 0;
        chk("a_halted", ia.halted, 1);
        chk("a_cyc_at_halt", ia.cycle_cnt, exp_cyc_a);
        ia.ex_branch = 1; #1;
        chk("a_halt_noflush", ia.flush, 0);
        tick(); tick();
        ia.ex_branch = 0;
        chk("a_cyc_frozen",     ia.cycle_cnt, exp_cyc_a);
        chk("a_halt_flush_cnt", ia.flush_cnt, 1);
        ia.go = 1;
        tick();
        chk("a_go_run", ia.halted, 0);
        run_a = 1; ia.go = 0;
        tick();
        chk("a_cyc_resume", ia.cycle_cnt, exp_cyc_a);
        ia.halt_req = 1;
        tick();
        ia.halt_req = 0; run_a = 0;
        chk("a_halted2", ia.halted, 1);
        clr_a = 1'b1; #1;
        chk("a_clr_halted", ia.halted, 0);
        chk("a_clr_cnts",   {ia.cycle_cnt, ia.stall_cnt, ia.flush_cnt}, 0);
        exp_cyc_a = 0;
        @(negedge clk);
        clr_a = 1'b0; run_a = 1;
        tick();

        // ---- forwarding unit ----
        id_b(1, 1, 2, 1, 1, 1, 3, 0);                     // ADDU $3
        tick();
        id_b(1, 3, 4, 1, 1, 1, 8, 0); #1;                 // SUBU $8, $3, $4
        chk("b_fwd1_stall", ib.stall, 0);
        chk("b_fwd1_rs",    ib.fwd_rs, 1);
        chk("b_fwd1_rt",    ib.fwd_rt, 0);
        tick();
        id_b(1, 3, 0, 1, 0, 0, 0, 0); #1;
        chk("b_fwd2_rs", ib.fwd_rs, 2);
        tick();
        id_b(1, 1, 0, 1, 0, 1, 5, 1);                     // LW $5
        tick();
        id_b(1, 0, 5, 0, 1, 1, 10, 0); #1;                // ADD $10, $0, $5
        chk("b_lu_stall", ib.stall, 1);
        chk("b_lu_fwd0",  ib.fwd_rt, 0);
        tick();
        chk("b_lu_release", ib.stall, 0);
        chk("b_lu_fwd_rt",  ib.fwd_rt, 2);
        tick();
        id_b(1, 0, 0, 0, 0, 1, 9, 0);                     // two writers of $9
        tick(); tick();
        id_b(1, 9, 0, 1, 0, 0, 0, 0); #1;
        chk("b_youngest", ib.fwd_rs, 1);
        ib.ex_branch = 1; #1;
        chk("b_flush",     ib.flush, 1);
        chk("b_flush_fwd", ib.fwd_rs, 0);
        tick();
        ib.ex_branch = 0; #1;
        chk("b_bubble_fwd", ib.fwd_rs, 2);
        chk("b_flush_cnt",  ib.flush_cnt, 1);
        chk("b_stall_cnt",  ib.stall_cnt, 1);
        id_b(1, 0, 0, 0, 0, 0, 0, 0); ib.id_lowrite = 1;  // MTLO
        tick();
        id_b(1, 0, 0, 0, 0, 1, 2, 0); ib.lo_used = 1; #1; // MFLO
        chk("b_lo_stall", ib.stall, 1);
        id_b(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("b_cyc_sat", ib.cycle_cnt, 4'hF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
